// File: rtl/param_ram_multibank_if.sv
// Host-side bus of the multi-bank parameter RAM: write port, read handshake and status.
// Optional macro PARAM_RAM_PARITY_EN adds the rd_perr status line.
interface param_ram_multibank_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int BANK_W = 2
);
  logic              wr_en;
  logic [BANK_W-1:0] wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              wr_err;
  // A read transfers on a rising edge where rd_req && rd_ready; its result comes
  // back as a one-cycle rd_valid pulse, and rd_data holds between pulses.
  logic              rd_req;
  logic [BANK_W-1:0] rd_bank;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              init_done;
  logic              dbg_state;
`ifdef PARAM_RAM_PARITY_EN
  logic              rd_perr;
`endif

  modport master (
    output wr_en, wr_bank, wr_addr, wr_data, rd_req, rd_bank, rd_addr,
    input  wr_ack, wr_err, rd_ready, rd_valid, rd_data, init_done, dbg_state
`ifdef PARAM_RAM_PARITY_EN
    , input rd_perr
`endif
  );

  modport slave (
    input  wr_en, wr_bank, wr_addr, wr_data, rd_req, rd_bank, rd_addr,
    output wr_ack, wr_err, rd_ready, rd_valid, rd_data, init_done, dbg_state
`ifdef PARAM_RAM_PARITY_EN
    , output rd_perr
`endif
  );
endinterface

// File: rtl/param_ram_multibank.sv
// NUM_BANKS banks of 2**ADDR_W words behind one shared port, with a post-reset clear
// sweep, a one-deep pending-read slot and even-parity storage under PARAM_RAM_PARITY_EN.
module param_ram_multibank #(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 4,
  parameter int                NUM_BANKS  = 3,
  parameter int                BANK_W     = 2,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input logic                  clk_A,
  input logic                  reset,
  param_ram_multibank_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
`ifdef PARAM_RAM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif
  localparam logic [BANK_W:0] NB = NUM_BANKS[BANK_W:0];

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  function automatic logic [WORD_W-1:0] pack_word(input logic [DATA_W-1:0] d);
`ifdef PARAM_RAM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  logic [WORD_W-1:0] mem_q [NUM_BANKS][DEPTH];

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              wr_ack_q, wr_err_q, rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              pend_valid_q;
  logic [BANK_W-1:0] pend_bank_q;
  logic [ADDR_W-1:0] pend_addr_q;
`ifdef PARAM_RAM_PARITY_EN
  logic              rd_perr_q;
`endif

  logic              run, rd_ready, wr_fire, wr_ok, rd_accept, rd_issue;
  logic [BANK_W-1:0] sel_bank;
  logic [ADDR_W-1:0] sel_addr;
  logic [WORD_W-1:0] rd_word_d;

  always_comb begin
    run       = (state_q == ST_RUN);
    rd_ready  = run && !pend_valid_q;
    wr_fire   = run && bus.wr_en;
    wr_ok     = ({1'b0, bus.wr_bank} < NB);
    rd_accept = bus.rd_req && rd_ready;
    // The pending slot is always served before a fresh request.
    rd_issue  = run && !bus.wr_en && (pend_valid_q || rd_accept);
    sel_bank  = pend_valid_q ? pend_bank_q : bus.rd_bank;
    sel_addr  = pend_valid_q ? pend_addr_q : bus.rd_addr;
    ptr_d     = ptr_q + ADDR_W'(1);
    rd_word_d = '0;
    if ({1'b0, sel_bank} < NB) rd_word_d = mem_q[sel_bank][sel_addr];
  end

  // Storage has no reset; the sweep initialises it once the FSM is in INIT.
  always_ff @(posedge clk_A) begin
    if (state_q == ST_INIT) begin
      for (int b = 0; b < NUM_BANKS; b++) mem_q[b][ptr_q] <= pack_word(INIT_VALUE);
    end else if (wr_fire && wr_ok) begin
      mem_q[bus.wr_bank][bus.wr_addr] <= pack_word(bus.wr_data);
    end
  end

  always_ff @(posedge clk_A or posedge reset) begin
    if (reset) begin
      state_q      <= ST_INIT;
      ptr_q        <= '0;
      wr_ack_q     <= 1'b0;
      wr_err_q     <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_bank_q  <= '0;
      pend_addr_q  <= '0;
`ifdef PARAM_RAM_PARITY_EN
      rd_perr_q    <= 1'b0;
`endif
    end else begin
      wr_ack_q   <= 1'b0;
      wr_err_q   <= 1'b0;
      rd_valid_q <= 1'b0;
`ifdef PARAM_RAM_PARITY_EN
      rd_perr_q  <= 1'b0;
`endif
      if (state_q == ST_INIT) begin
        ptr_q <= ptr_d;
        if (ptr_q == ADDR_W'(DEPTH - 1)) state_q <= ST_RUN;
      end else if (bus.wr_en) begin
        wr_ack_q <= wr_ok;
        wr_err_q <= !wr_ok;
        if (rd_accept) begin
          pend_valid_q <= 1'b1;
          pend_bank_q  <= bus.rd_bank;
          pend_addr_q  <= bus.rd_addr;
        end
      end else if (rd_issue) begin
        rd_valid_q   <= 1'b1;
        rd_data_q    <= rd_word_d[DATA_W-1:0];
        pend_valid_q <= 1'b0;
`ifdef PARAM_RAM_PARITY_EN
        rd_perr_q    <= ^rd_word_d;
`endif
      end
    end
  end

  assign bus.wr_ack    = wr_ack_q;
  assign bus.wr_err    = wr_err_q;
  assign bus.rd_ready  = rd_ready;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.init_done = run;
  assign bus.dbg_state = state_q;
`ifdef PARAM_RAM_PARITY_EN
  assign bus.rd_perr   = rd_perr_q;
`endif
endmodule
